// File: rtl/veda_mem_ctrl_if.sv
// Datapath-side channels of the scratch-memory burst master: command,
// write-data and read-data handshakes plus burst status.
interface veda_mem_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
endinterface

// File: rtl/veda_mem_ctrl.sv
// Burst master for the single-port scratch memory: walks an address counter
// for write/read bursts and streams beats over valid/ready channels.
module veda_mem_ctrl #(
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter bit MODE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  veda_mem_ctrl_if.slave bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_mode,
  input  logic [DW-1:0] mem_q
);

  localparam logic [1:0]    RL  = MODE ? 2'd2 : 2'd1;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_HOLD} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_cnt_q;
  logic [AW-1:0] beat_cnt_q;
  logic [1:0]    wait_cnt_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_cnt_q <= bus.cmd_addr;
            beat_cnt_q <= bus.cmd_len;
            wait_cnt_q <= RL;
            state_q    <= bus.cmd_write ? WRITE : RD_WAIT;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            addr_cnt_q <= addr_cnt_q + ONE;
            if (beat_cnt_q == ZERO) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q - ONE;
            end
          end
        end
        // Address has been stable since entry; after RL counting cycles the
        // memory's registered q reflects it and is captured on the next edge.
        RD_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            rd_data_q  <= mem_q;
            rd_valid_q <= 1'b1;
            state_q    <= RD_HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        RD_HOLD: begin
          if (rd_valid_q && bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            if (beat_cnt_q == ZERO) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              addr_cnt_q <= addr_cnt_q + ONE;
              beat_cnt_q <= beat_cnt_q - ONE;
              wait_cnt_q <= RL;
              state_q    <= RD_WAIT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;

  assign mem_we   = (state_q == WRITE) && bus.wr_valid;
  assign mem_addr = addr_cnt_q;
  assign mem_din  = bus.wr_data;
  assign mem_mode = MODE;

  a_rd_hold: assert property (@(posedge clk) disable iff (!rst)
    rd_valid_q && !bus.rd_ready |=> rd_valid_q && $stable(rd_data_q));

  a_done_idle: assert property (@(posedge clk) disable iff (!rst)
    done_q |-> state_q == IDLE);

endmodule

// File: tb/tb_veda_mem_ctrl.sv
// Randomized bench for veda_mem_ctrl: MODE=1 and MODE=0 instances, each on a
// behavioural scratch memory, with a reference array and read-data scoreboard.
module tb_veda_mem_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  veda_mem_ctrl_if #(.AW(AW), .DW(DW)) b1 ();
  veda_mem_ctrl_if #(.AW(AW), .DW(DW)) b0 ();

  logic          mw1, mw0, mm1, mm0;
  logic [AW-1:0] ma1, ma0;
  logic [DW-1:0] md1, md0;
  logic [DW-1:0] mq1 = '0;
  logic [DW-1:0] mq0 = '0;

  veda_mem_ctrl #(.AW(AW), .DW(DW), .MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .mem_we(mw1), .mem_addr(ma1), .mem_din(md1), .mem_mode(mm1), .mem_q(mq1));

  veda_mem_ctrl #(.AW(AW), .DW(DW), .MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .mem_we(mw0), .mem_addr(ma0), .mem_din(md0), .mem_mode(mm0), .mem_q(mq0));

  // Scratch memory models: registered q, MODE=1 re-registers the address.
  logic [DW-1:0] mem1 [32] = '{default: '0};
  logic [DW-1:0] mem0 [32] = '{default: '0};
  logic [AW-1:0] aq1 = '0;
  always @(posedge clk) begin
    if (mw1) mem1[ma1] <= md1;
    aq1 <= ma1;
    mq1 <= mem1[aq1];
  end
  always @(posedge clk) begin
    if (mw0) mem0[ma0] <= md0;
    mq0 <= mem0[ma0];
  end

  // Shared stimulus steered to the instance picked by sel0.
  logic          sel0 = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic [DW-1:0] wr_data = '0;

  assign b1.cmd_valid = cmd_valid & ~sel0;
  assign b0.cmd_valid = cmd_valid & sel0;
  assign b1.cmd_write = cmd_write;
  assign b0.cmd_write = cmd_write;
  assign b1.cmd_addr  = cmd_addr;
  assign b0.cmd_addr  = cmd_addr;
  assign b1.cmd_len   = cmd_len;
  assign b0.cmd_len   = cmd_len;
  assign b1.wr_valid  = wr_valid & ~sel0;
  assign b0.wr_valid  = wr_valid & sel0;
  assign b1.wr_data   = wr_data;
  assign b0.wr_data   = wr_data;
  assign b1.rd_ready  = rd_ready & ~sel0;
  assign b0.rd_ready  = rd_ready & sel0;

  logic          cmd_ready, wr_ready, rd_valid, busy, done, mem_we, mem_mode;
  logic [DW-1:0] rd_data, mem_din;
  logic [AW-1:0] mem_addr;
  assign cmd_ready = sel0 ? b0.cmd_ready : b1.cmd_ready;
  assign wr_ready  = sel0 ? b0.wr_ready  : b1.wr_ready;
  assign rd_valid  = sel0 ? b0.rd_valid  : b1.rd_valid;
  assign rd_data   = sel0 ? b0.rd_data   : b1.rd_data;
  assign busy      = sel0 ? b0.busy      : b1.busy;
  assign done      = sel0 ? b0.done      : b1.done;
  assign mem_we    = sel0 ? mw0 : mw1;
  assign mem_addr  = sel0 ? ma0 : ma1;
  assign mem_din   = sel0 ? md0 : md1;
  assign mem_mode  = sel0 ? mm0 : mm1;

  // Reference model and scoreboard state.
  logic [DW-1:0] ref_mem [2][32] = '{default: '0};
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] fixd [4];
  bit            use_fix = 1'b0;
  int            vectors = 0, errors = 0;
  int            exp_done = 0, done_seen = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check("rd_unexpected_beat", 32'(rd_data), 32'hDEAD);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    done_seen <= done_seen + int'(b1.done) + int'(b0.done);
  end

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input int stall_beat, input bit ghost);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int n;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len; #1;
    check("wr_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = AW'($urandom); cmd_len = AW'($urandom);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + b[AW-1:0];
      n = (b == stall_beat) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      repeat (n) begin
        wr_valid = 1'b0; wr_data = DW'($urandom); cmd_valid = ghost; #1;
        check("wr_stall_we", 32'(mem_we), 0);
        check("wr_stall_addr", 32'(mem_addr), 32'(a));
        check("wr_stall_ready", 32'(wr_ready), 1);
        if (ghost) check("busy_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #1;
      end
      d = use_fix ? fixd[b] : DW'($urandom);
      wr_valid = 1'b1; wr_data = d; cmd_valid = ghost && (b < int'(len)); #1;
      check("wr_we", 32'(mem_we), 1);
      check("wr_addr", 32'(mem_addr), 32'(a));
      check("wr_din", 32'(mem_din), 32'(d));
      if (ghost) check("busy_cmd_ready", 32'(cmd_ready), 0);
      ref_mem[sel0][a] = d;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; cmd_valid = 1'b0; #1;
    check("wr_done", 32'(done), 1);
    check("wr_done_cmd_ready", 32'(cmd_ready), 1);
    check("wr_done_busy", 32'(busy), 0);
    exp_done++;
  endtask

  task automatic rd_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int bp_beat);
    logic [AW-1:0] a;
    logic [DW-1:0] d0;
    int n, acc, hold, rl;
    rl = sel0 ? 1 : 2;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len; #1;
    check("rd_cmd_ready", 32'(cmd_ready), 1);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + b[AW-1:0];
      exp_q.push_back(ref_mem[sel0][a]);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; acc = cyc;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + b[AW-1:0];
      n = 0;
      while (!rd_valid && n < 12) begin
        @(posedge clk); #1; n++;
      end
      if (!rd_valid) begin
        check("rd_timeout", 0, 1);
        exp_q.delete();
        return;
      end
      check("rd_latency", 32'(cyc - acc), 32'(rl + 1));
      check("rd_addr", 32'(mem_addr), 32'(a));
      d0 = rd_data;
      hold = (b == bp_beat) ? 5 : int'($urandom_range(0, 2));
      repeat (hold) begin
        @(posedge clk); #1;
        check("rd_hold_valid", 32'(rd_valid), 1);
        check("rd_hold_data", 32'(rd_data), 32'(d0));
        check("rd_hold_addr", 32'(mem_addr), 32'(a));
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0; acc = cyc;
      check("rd_valid_drop", 32'(rd_valid), 0);
    end
    check("rd_done", 32'(done), 1);
    check("rd_done_cmd_ready", 32'(cmd_ready), 1);
    exp_done++;
  endtask

  initial begin
    logic [AW-1:0] a, l, ra, rlen;
    int ds;
    #1 rst = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("mem_mode1", 32'(mem_mode), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Reset during the 3rd beat of a len=7 write at address 0.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = 5'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = DW'($urandom); ref_mem[0][b] = wr_data;
      @(posedge clk); #1;
    end
    wr_valid = 1'b1; wr_data = 8'hEE; rst = 1'b0; #1;
    check("midrst_we", 32'(mem_we), 0);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    check("midrst_wr_ready", 32'(wr_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;
    rst = 1'b1; wr_valid = 1'b0; ds = done_seen;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_seen), 32'(ds));
    check("midrst_idle", 32'(busy), 0);
    rd_burst(5'd0, 5'd7, -1);

    // Single beat write then read.
    use_fix = 1'b1; fixd[0] = 8'hA5;
    wr_burst(5'd5, 5'd0, -1, 1'b0);
    use_fix = 1'b0;
    rd_burst(5'd5, 5'd0, -1);

    // Wrap across the top of the address space.
    use_fix = 1'b1;
    fixd[0] = 8'h11; fixd[1] = 8'h22; fixd[2] = 8'h33; fixd[3] = 8'h44;
    wr_burst(5'd30, 5'd3, -1, 1'b0);
    use_fix = 1'b0;
    rd_burst(5'd30, 5'd3, -1);

    // Forced write stall, then read backpressure on beat 2.
    wr_burst(5'd10, 5'd5, 2, 1'b0);
    rd_burst(5'd10, 5'd3, 2);
    rd_burst(5'd10, 5'd5, -1);

    for (int it = 0; it < 8; it++) begin
      a = AW'($urandom);
      l = (it == 3) ? 5'd31 : AW'($urandom_range(0, 9));
      wr_burst(a, l, -1, 1'b0);
      rd_burst(a, l, -1);
      ra = AW'($urandom);
      rlen = AW'($urandom_range(0, 6));
      rd_burst(ra, rlen, -1);
    end

    // MODE=0 instance: shorter read latency, commands ignored while busy.
    sel0 = 1'b1;
    @(posedge clk); #1;
    check("mem_mode0", 32'(mem_mode), 0);
    wr_burst(5'd3, 5'd2, 1, 1'b1);
    @(posedge clk); #1;
    check("mode0_no_second_burst", 32'(busy), 0);
    rd_burst(5'd3, 5'd2, 1);
    rd_burst(5'd2, 5'd4, -1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("done_count", 32'(done_seen), 32'(exp_done));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
